// File: rtl/conv_window_scheduler_pkg.sv
// Shared types for the convolution window scheduler.
//   coord_t       : packed (x, y) event / output-map coordinate
//   scan_state_t  : scheduler FSM encoding
//   win_update_t  : one neighbourhood update (output coord + kernel weight index)
//   in_bounds()   : signed coordinate range check against the output map size
package conv_window_scheduler_pkg;

  localparam int COORD_W  = 8;
  localparam int KERNEL_K = 3;
  localparam int KIDX_W   = $clog2(KERNEL_K * KERNEL_K);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE,
    S_RELEASE
  } scan_state_t;

  typedef struct packed {
    coord_t            coord;
    logic [KIDX_W-1:0] kidx;
  } win_update_t;

  typedef logic signed [COORD_W:0] scoord_t;

  function automatic logic in_bounds(input scoord_t ox, input scoord_t oy,
                                     input int w, input int h);
    return !ox[COORD_W] && !oy[COORD_W] && (int'(ox) < w) && (int'(oy) < h);
  endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Window-update stream from the scheduler to the convolution compute stage.
//   win_coord_o : output-map coordinate to update
//   win_kidx_o  : kernel weight index ky*K+kx
//   win_valid_o : win_* valid
//   win_ready_i : downstream accepts win_* when valid && ready
// master = scheduler side, slave = compute side.
interface conv_window_scheduler_if;
  import conv_window_scheduler_pkg::*;

  coord_t            win_coord_o;
  logic [KIDX_W-1:0] win_kidx_o;
  logic              win_valid_o;
  logic              win_ready_i;

  modport master (output win_coord_o, output win_kidx_o, output win_valid_o,
                  input  win_ready_i);
  modport slave  (input  win_coord_o, input  win_kidx_o, input  win_valid_o,
                  output win_ready_i);
endinterface

// File: rtl/conv_window_scheduler.sv
// Expands one captured event coordinate into the KxK neighbourhood of output
// updates (ox = x+R-kx, oy = y+R-ky, kidx = ky*K+kx), skipping cells that fall
// outside the output map, and pulses event_processed_o once the last update
// has been accepted.
//   clk, reset_ni       : clock, asynchronous active-low reset
//   enable_i            : low aborts the current event and idles
//   event_coord_i/valid : captured event, level valid held until released
//   event_processed_o   : one-cycle pulse when the event is fully scheduled
//   busy_o              : high whenever the FSM is not idle
//   win (master)        : registered update stream with valid/ready handshake
module conv_window_scheduler
  import conv_window_scheduler_pkg::*;
#(
  parameter int COORD_BITS  = COORD_W,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = KERNEL_K
) (
  input  logic                           clk,
  input  logic                           reset_ni,
  input  logic                           enable_i,
  input  coord_t                         event_coord_i,
  input  logic                           event_valid_i,
  output logic                           event_processed_o,
  output logic                           busy_o,
  conv_window_scheduler_if.master        win
);

  localparam int R     = (KERNEL_SIZE - 1) / 2;
  localparam int CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [COORD_BITS:0] R_EXT    = (COORD_BITS + 1)'(R);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(KERNEL_SIZE - 1);

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic              cells_done_q, cells_done_d;
  coord_t            lat_q, lat_d;
  win_update_t       out_q, out_d;
  logic              wv_q, wv_d;

  logic signed [COORD_BITS:0] ox, oy;
  logic                       cell_ok;
  logic                       can_load;
  logic [KIDX_W-1:0]          kidx_cur;

  // Zero-extend to COORD_BITS+1 so a negative result shows in the sign bit.
  assign ox = {1'b0, lat_q.x} + R_EXT - {{(COORD_BITS + 1 - CNT_W){1'b0}}, kx_q};
  assign oy = {1'b0, lat_q.y} + R_EXT - {{(COORD_BITS + 1 - CNT_W){1'b0}}, ky_q};
  assign cell_ok  = in_bounds(ox, oy, IMG_WIDTH, IMG_HEIGHT);
  assign kidx_cur = KIDX_W'(int'(ky_q) * KERNEL_SIZE + int'(kx_q));
  assign can_load = !wv_q || win.win_ready_i;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      kx_q         <= '0;
      ky_q         <= '0;
      cells_done_q <= 1'b0;
      lat_q        <= '0;
      out_q        <= '0;
      wv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      cells_done_q <= cells_done_d;
      lat_q        <= lat_d;
      out_q        <= out_d;
      wv_q         <= wv_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    kx_d              = kx_q;
    ky_d              = ky_q;
    cells_done_d      = cells_done_q;
    lat_d             = lat_q;
    out_d             = out_q;
    wv_d              = wv_q;
    event_processed_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i && event_valid_i) begin
          lat_d        = event_coord_i;
          kx_d         = '0;
          ky_d         = '0;
          cells_done_d = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        // cells_done marks that the last cell has been issued; the FSM then
        // lingers in SCAN until that final update drains from the register.
        if (can_load) begin
          if (!cells_done_q) begin
            wv_d = cell_ok;
            if (cell_ok) begin
              out_d.coord.x = ox[COORD_BITS-1:0];
              out_d.coord.y = oy[COORD_BITS-1:0];
              out_d.kidx    = kidx_cur;
            end
            if (kx_q == CNT_LAST) begin
              kx_d = '0;
              if (ky_q == CNT_LAST) begin
                ky_d         = '0;
                cells_done_d = 1'b1;
              end else begin
                ky_d = ky_q + 1'b1;
              end
            end else begin
              kx_d = kx_q + 1'b1;
            end
          end else begin
            wv_d         = 1'b0;
            cells_done_d = 1'b0;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        event_processed_o = 1'b1;
        state_d           = S_RELEASE;
      end
      S_RELEASE: begin
        if (!event_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable_i) begin
      state_d      = S_IDLE;
      wv_d         = 1'b0;
      kx_d         = '0;
      ky_d         = '0;
      cells_done_d = 1'b0;
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign win.win_valid_o = wv_q;
  assign win.win_coord_o = out_q.coord;
  assign win.win_kidx_o  = out_q.kidx;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed self-checking bench for conv_window_scheduler (32x32 map, K=3).
module tb_conv_window_scheduler;
  import conv_window_scheduler_pkg::*;

  logic   clk = 1'b0;
  logic   reset_ni;
  logic   enable_i;
  coord_t event_coord_i;
  logic   event_valid_i;
  logic   event_processed_o;
  logic   busy_o;

  conv_window_scheduler_if win_if ();

  conv_window_scheduler #(
    .COORD_BITS (8),
    .IMG_WIDTH  (32),
    .IMG_HEIGHT (32),
    .KERNEL_SIZE(3)
  ) dut (
    .clk              (clk),
    .reset_ni         (reset_ni),
    .enable_i         (enable_i),
    .event_coord_i    (event_coord_i),
    .event_valid_i    (event_valid_i),
    .event_processed_o(event_processed_o),
    .busy_o           (busy_o),
    .win              (win_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log of accepted updates and processed pulses, sampled on the falling edge.
  int qx[$], qy[$], qk[$], qc[$];
  int pulses    = 0;
  int pulse_cyc = 0;
  always @(negedge clk) begin
    if (win_if.win_valid_o && win_if.win_ready_i) begin
      qx.push_back(int'(win_if.win_coord_o.x));
      qy.push_back(int'(win_if.win_coord_o.y));
      qk.push_back(int'(win_if.win_kidx_o));
      qc.push_back(cyc);
    end
    if (event_processed_o) begin
      pulses++;
      pulse_cyc = cyc;
    end
  end

  task automatic clear_log();
    qx.delete(); qy.delete(); qk.delete(); qc.delete();
    pulses = 0;
  endtask

  task automatic start_event(input int x, input int y, output int t0);
    @(posedge clk); #1;
    event_coord_i.x = 8'(x);
    event_coord_i.y = 8'(y);
    event_valid_i   = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_pulse(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (event_processed_o) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Hold valid a few cycles after the pulse, then drop it and let the FSM idle.
  task automatic release_event(input int hold);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    event_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; enable_i = 1'b0; event_valid_i = 1'b0;
    event_coord_i = '0; win_if.win_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b expected 0", busy_o); end
    n_cmp++; if (win_if.win_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b expected 0", win_if.win_valid_o); end
    n_cmp++; if (event_processed_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b expected 0", event_processed_o); end
    n_cmp++; if (win_if.win_coord_o !== 16'h0000) begin n_fail++; $display("FAIL reset_coord got %h expected 0000", win_if.win_coord_o); end
    n_cmp++; if (win_if.win_kidx_o !== 4'd0) begin n_fail++; $display("FAIL reset_kidx got %0d expected 0", win_if.win_kidx_o); end
    reset_ni = 1'b1;
    enable_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_interior();
    int ex[9] = '{6, 5, 4, 6, 5, 4, 6, 5, 4};
    int ey[9] = '{6, 6, 6, 5, 5, 5, 4, 4, 4};
    int t0;
    bit to;
    clear_log();
    start_event(5, 5, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL interior_timeout got timeout expected pulse"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL interior_release_busy got %0b expected 1", busy_o); end
    end
    release_event(0);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL interior_idle got busy=%0b expected 0", busy_o); end
    n_cmp++; if (qx.size() !== 9) begin n_fail++; $display("FAIL interior_count got %0d expected 9", qx.size()); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL interior_pulses got %0d expected 1", pulses); end
    if (qx.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (qx[i] !== ex[i] || qy[i] !== ey[i] || qk[i] !== i || qc[i] !== t0 + 2 + i) begin
          n_fail++;
          $display("FAIL interior_upd%0d got (%0d,%0d,k%0d)@%0d expected (%0d,%0d,k%0d)@%0d",
                   i, qx[i], qy[i], qk[i], qc[i], ex[i], ey[i], i, t0 + 2 + i);
        end
      end
      n_cmp++; if (pulse_cyc !== qc[8] + 1) begin n_fail++; $display("FAIL interior_pulse_cycle got %0d expected %0d", pulse_cyc, qc[8] + 1); end
    end
  endtask

  task automatic test_corner_origin();
    int ex[4] = '{1, 0, 1, 0};
    int ey[4] = '{1, 1, 0, 0};
    int ek[4] = '{0, 1, 3, 4};
    int t0;
    bit to;
    clear_log();
    start_event(0, 0, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL origin_timeout got timeout expected pulse"); end
    release_event(2);
    n_cmp++; if (qx.size() !== 4) begin n_fail++; $display("FAIL origin_count got %0d expected 4", qx.size()); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL origin_pulses got %0d expected 1", pulses); end
    if (qx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (qx[i] !== ex[i] || qy[i] !== ey[i] || qk[i] !== ek[i]) begin
          n_fail++;
          $display("FAIL origin_upd%0d got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                   i, qx[i], qy[i], qk[i], ex[i], ey[i], ek[i]);
        end
      end
    end
  endtask

  task automatic test_corner_max();
    int ex[4] = '{31, 30, 31, 30};
    int ey[4] = '{31, 31, 30, 30};
    int ek[4] = '{4, 5, 7, 8};
    int t0;
    bit to;
    clear_log();
    start_event(31, 31, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL max_timeout got timeout expected pulse"); end
    release_event(2);
    n_cmp++; if (qx.size() !== 4) begin n_fail++; $display("FAIL max_count got %0d expected 4", qx.size()); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL max_pulses got %0d expected 1", pulses); end
    if (qx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (qx[i] !== ex[i] || qy[i] !== ey[i] || qk[i] !== ek[i]) begin
          n_fail++;
          $display("FAIL max_upd%0d got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                   i, qx[i], qy[i], qk[i], ex[i], ey[i], ek[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int ex[9] = '{6, 5, 4, 6, 5, 4, 6, 5, 4};
    int ey[9] = '{6, 6, 6, 5, 5, 5, 4, 4, 4};
    int t0;
    bit done = 1'b0;
    bit have_prev = 1'b0;
    logic   prev_v, prev_r;
    coord_t prev_c;
    logic [3:0] prev_k;
    int stalls = 0;
    clear_log();
    start_event(5, 5, t0);
    win_if.win_ready_i = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      win_if.win_ready_i = ~win_if.win_ready_i;
      @(negedge clk);
      if (have_prev && prev_v && !prev_r) begin
        stalls++;
        n_cmp++;
        if (win_if.win_valid_o !== 1'b1 || win_if.win_coord_o !== prev_c || win_if.win_kidx_o !== prev_k) begin
          n_fail++;
          $display("FAIL stall_hold got v=%0b %h k%0d expected v=1 %h k%0d",
                   win_if.win_valid_o, win_if.win_coord_o, win_if.win_kidx_o, prev_c, prev_k);
        end
      end
      prev_v = win_if.win_valid_o; prev_r = win_if.win_ready_i;
      prev_c = win_if.win_coord_o; prev_k = win_if.win_kidx_o;
      have_prev = 1'b1;
      if (event_processed_o) done = 1'b1;
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_timeout got timeout expected pulse"); end
    n_cmp++; if (stalls < 1) begin n_fail++; $display("FAIL stall_seen got %0d expected at least 1", stalls); end
    win_if.win_ready_i = 1'b1;
    release_event(1);
    n_cmp++; if (qx.size() !== 9) begin n_fail++; $display("FAIL stall_count got %0d expected 9", qx.size()); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL stall_pulses got %0d expected 1", pulses); end
    if (qx.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (qx[i] !== ex[i] || qy[i] !== ey[i] || qk[i] !== i) begin
          n_fail++;
          $display("FAIL stall_upd%0d got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                   i, qx[i], qy[i], qk[i], ex[i], ey[i], i);
        end
      end
    end
  endtask

  task automatic test_release();
    int t0;
    bit to;
    clear_log();
    start_event(2, 2, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL release_timeout got timeout expected pulse"); end
    // A different coordinate presented while valid is still high must be ignored.
    @(posedge clk); #1;
    event_coord_i.x = 8'd20;
    event_coord_i.y = 8'd20;
    repeat (3) @(negedge clk);
    n_cmp++; if (qx.size() !== 9) begin n_fail++; $display("FAIL release_no_rescan got %0d updates expected 9", qx.size()); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL release_busy got %0b expected 1", busy_o); end
    release_event(0);
    start_event(20, 20, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL release_next_timeout got timeout expected pulse"); end
    release_event(1);
    n_cmp++; if (qx.size() !== 18) begin n_fail++; $display("FAIL release_total got %0d expected 18", qx.size()); end
    n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL release_pulses got %0d expected 2", pulses); end
    if (qx.size() == 18) begin
      n_cmp++;
      if (qx[9] !== 21 || qy[9] !== 21 || qk[9] !== 0 || qc[9] !== t0 + 2) begin
        n_fail++;
        $display("FAIL release_next_first got (%0d,%0d,k%0d)@%0d expected (21,21,k0)@%0d",
                 qx[9], qy[9], qk[9], qc[9], t0 + 2);
      end
    end
  endtask

  task automatic test_enable_abort();
    int t0;
    int n = 0;
    bit to;
    clear_log();
    start_event(5, 5, t0);
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (win_if.win_valid_o && win_if.win_ready_i) n++;
    end
    n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL abort_reach3 got %0d expected 3", n); end
    enable_i = 1'b0;
    event_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (win_if.win_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %0b expected 0", win_if.win_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b expected 0", busy_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (qx.size() !== 3) begin n_fail++; $display("FAIL abort_count got %0d expected 3", qx.size()); end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_pulses got %0d expected 0", pulses); end
    clear_log();
    enable_i = 1'b1;
    start_event(10, 10, t0);
    wait_pulse(40, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL reenable_timeout got timeout expected pulse"); end
    release_event(1);
    n_cmp++; if (qx.size() !== 9) begin n_fail++; $display("FAIL reenable_count got %0d expected 9", qx.size()); end
    if (qx.size() == 9) begin
      n_cmp++;
      if (qx[0] !== 11 || qy[0] !== 11 || qk[0] !== 0 || qx[8] !== 9 || qy[8] !== 9 || qk[8] !== 8) begin
        n_fail++;
        $display("FAIL reenable_ends got (%0d,%0d,k%0d)..(%0d,%0d,k%0d) expected (11,11,k0)..(9,9,k8)",
                 qx[0], qy[0], qk[0], qx[8], qy[8], qk[8]);
      end
    end
  endtask

  task automatic test_async_reset();
    int t0;
    int n = 0;
    start_event(5, 5, t0);
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (win_if.win_valid_o && win_if.win_ready_i) n++;
    end
    #1 reset_ni = 1'b0;
    #1;
    n_cmp++; if (win_if.win_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %0b expected 0", win_if.win_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %0b expected 0", busy_o); end
    n_cmp++; if (win_if.win_coord_o !== 16'h0000 || win_if.win_kidx_o !== 4'd0) begin
      n_fail++; $display("FAIL areset_data got %h k%0d expected 0000 k0", win_if.win_coord_o, win_if.win_kidx_o);
    end
    event_valid_i = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_interior();
    test_corner_origin();
    test_corner_max();
    test_stall();
    test_release();
    test_enable_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
